// File: rtl/image_rotator.sv
// Frame buffer that captures a raster image and replays it transposed or rotated.
// Define IMAGE_ROTATOR_ROT180_EN to enable rot_mode 3 (rotate 180); otherwise mode 3 falls back to transpose and flags err.
module image_rotator #(
  parameter int PIX_W = 24,
  parameter int CRD_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [1:0]       rot_mode,
  input  logic             valid_in,
  input  logic [PIX_W-1:0] data_in,
  input  logic             jump_in,
  input  logic             eof_in,
  output logic [PIX_W-1:0] data_out,
  output logic             valid_out,
  output logic             jump_out,
  output logic             eof_out,
  output logic             busy,
  output logic             err
);

  localparam int DIM_W = CRD_W + 1;
  localparam logic [DIM_W-1:0] MAX_DIM = {1'b1, {CRD_W{1'b0}}};
  localparam logic [DIM_W-1:0] ONE_D   = DIM_W'(1);
  localparam logic [CRD_W-1:0] ONE_C   = CRD_W'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0] mem [0:(1<<(2*CRD_W))-1];

  logic [1:0]       mode_q, mode_start;
  logic             bad_mode;
  logic [DIM_W-1:0] col_cnt, row_cnt, row_len;
  logic [DIM_W-1:0] img_w, img_h, out_i, out_j, out_cols, out_rows;
  logic [CRD_W-1:0] src_r, src_c, i_c, j_c, w_c, h_c;
  logic             row_end, wr_ok, rd_en, col_last, frame_last;

`ifdef IMAGE_ROTATOR_ROT180_EN
  assign mode_start = rot_mode;
  assign bad_mode   = 1'b0;
`else
  assign mode_start = (rot_mode == 2'd3) ? 2'd0 : rot_mode;
  assign bad_mode   = (rot_mode == 2'd3);
`endif

  // eof_in always terminates the current row, even if jump_in was left low
  assign row_end = jump_in | eof_in;
  assign row_len = col_cnt + ONE_D;
  assign wr_ok   = (state == WRITE) && valid_in && (col_cnt < MAX_DIM) && (row_cnt < MAX_DIM);
  assign rd_en   = (state == READ);
  assign busy    = (state != IDLE);

  assign out_cols   = (mode_q == 2'd3) ? img_w : img_h;
  assign out_rows   = (mode_q == 2'd3) ? img_h : img_w;
  assign col_last   = (out_j == out_cols - ONE_D);
  assign frame_last = rd_en && col_last && (out_i == out_rows - ONE_D);

  assign i_c = out_i[CRD_W-1:0];
  assign j_c = out_j[CRD_W-1:0];
  assign w_c = img_w[CRD_W-1:0];
  assign h_c = img_h[CRD_W-1:0];

  always_comb begin
    src_r = j_c;
    src_c = i_c;
    case (mode_q)
      2'd1: begin
        src_r = h_c - ONE_C - j_c;
        src_c = i_c;
      end
      2'd2: begin
        src_r = j_c;
        src_c = w_c - ONE_C - i_c;
      end
      2'd3: begin
        src_r = h_c - ONE_C - i_c;
        src_c = w_c - ONE_C - j_c;
      end
      default: begin
        src_r = j_c;
        src_c = i_c;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in)           state_nxt = WRITE;
      WRITE:   if (valid_in && eof_in) state_nxt = READ;
      READ:    if (frame_last)         state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Pixel store has no reset; contents are only meaningful once written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{row_cnt[CRD_W-1:0], col_cnt[CRD_W-1:0]}] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      jump_out  <= 1'b0;
      eof_out   <= 1'b0;
      err       <= 1'b0;
      mode_q    <= 2'd0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      img_w     <= '0;
      img_h     <= '0;
      out_i     <= '0;
      out_j     <= '0;
    end else begin
      valid_out <= rd_en;
      jump_out  <= rd_en && col_last;
      eof_out   <= frame_last;
      if (rd_en) data_out <= mem[{src_r, src_c}];
      case (state)
        IDLE: if (start_in) begin
          mode_q  <= mode_start;
          err     <= bad_mode;
          col_cnt <= '0;
          row_cnt <= '0;
          img_w   <= '0;
          img_h   <= '0;
        end
        WRITE: if (valid_in) begin
          if (!wr_ok) err <= 1'b1;
          if (row_end) begin
            col_cnt <= '0;
            if (row_cnt == '0)          img_w <= (row_len > MAX_DIM) ? MAX_DIM : row_len;
            else if (row_len != img_w)  err   <= 1'b1;
            if (row_cnt < MAX_DIM)      row_cnt <= row_cnt + ONE_D;
            if (eof_in) begin
              img_h <= (row_cnt < MAX_DIM) ? row_cnt + ONE_D : MAX_DIM;
              out_i <= '0;
              out_j <= '0;
            end
          end else if (col_cnt < MAX_DIM) begin
            col_cnt <= col_cnt + ONE_D;
          end
        end
        READ: begin
          if (col_last) begin
            out_j <= '0;
            out_i <= out_i + ONE_D;
          end else begin
            out_j <= out_j + ONE_D;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_rotator.sv
// Directed self-checking bench for image_rotator: rotation modes, 1x1 frame, row mismatch, reset in READ, ignored start.
module tb_image_rotator;

  localparam int PIX_W = 8;
  localparam int CRD_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_in;
  logic [1:0]       rot_mode;
  logic             valid_in;
  logic [PIX_W-1:0] data_in;
  logic             jump_in;
  logic             eof_in;
  logic [PIX_W-1:0] data_out;
  logic             valid_out;
  logic             jump_out;
  logic             eof_out;
  logic             busy;
  logic             err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [PIX_W-1:0] cap_d [16];
  logic             cap_j [16];
  logic             cap_e [16];
  int               cap_n;

  image_rotator #(.PIX_W(PIX_W), .CRD_W(CRD_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .rot_mode(rot_mode),
    .valid_in(valid_in), .data_in(data_in), .jump_in(jump_in), .eof_in(eof_in),
    .data_out(data_out), .valid_out(valid_out), .jump_out(jump_out),
    .eof_out(eof_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] mode);
    start_in = 1'b1;
    rot_mode = mode;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send_pixel(input logic [PIX_W-1:0] d, input logic j, input logic e);
    valid_in = 1'b1;
    data_in  = d;
    jump_in  = j;
    eof_in   = e;
    tick();
    valid_in = 1'b0;
    jump_in  = 1'b0;
    eof_in   = 1'b0;
  endtask

  task automatic send_frame_3x2();
    for (int k = 0; k < 6; k++) send_pixel(PIX_W'(k), (k % 3) == 2, k == 5);
  endtask

  // Gathers output pixels until eof_out or a bounded cycle budget expires
  task automatic capture();
    cap_n = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      tick();
      if (valid_out) begin
        if (cap_n < 16) begin
          cap_d[cap_n] = data_out;
          cap_j[cap_n] = jump_out;
          cap_e[cap_n] = eof_out;
        end
        cap_n++;
        if (eof_out) break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (data_out !== '0)   begin tests_failed++; $display("[TB] FAIL reset_data_out got %h want 0", data_out); end
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid_out got %b want 0", valid_out); end
    tests_run++; if (jump_out !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_jump_out got %b want 0", jump_out); end
    tests_run++; if (eof_out !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_eof_out got %b want 0", eof_out); end
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (err !== 1'b0)       begin tests_failed++; $display("[TB] FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic run_rotation_case(input string name, input logic [1:0] mode,
                                   input logic [PIX_W-1:0] exp_d [6],
                                   input logic [5:0] exp_jump, input logic exp_err);
    do_start(mode);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_busy got %b want 1", name, busy); end
    send_frame_3x2();
    capture();
    tests_run++; if (cap_n != 6) begin tests_failed++; $display("[TB] FAIL %s_count got %0d want 6", name, cap_n); end
    for (int k = 0; k < 6 && k < cap_n; k++) begin
      tests_run++; if (cap_d[k] !== exp_d[k])     begin tests_failed++; $display("[TB] FAIL %s_data[%0d] got %0d want %0d", name, k, cap_d[k], exp_d[k]); end
      tests_run++; if (cap_j[k] !== exp_jump[k])  begin tests_failed++; $display("[TB] FAIL %s_jump[%0d] got %b want %b", name, k, cap_j[k], exp_jump[k]); end
      tests_run++; if (cap_e[k] !== (k == 5))     begin tests_failed++; $display("[TB] FAIL %s_eof[%0d] got %b want %b", name, k, cap_e[k], k == 5); end
    end
    tests_run++; if (err !== exp_err) begin tests_failed++; $display("[TB] FAIL %s_err got %b want %b", name, err, exp_err); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_idle_busy got %b want 0", name, busy); end
  endtask

  task automatic test_modes();
    run_rotation_case("transpose", 2'd0, '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5}, 6'b101010, 1'b0);
    run_rotation_case("rot_cw",    2'd1, '{8'd3, 8'd0, 8'd4, 8'd1, 8'd5, 8'd2}, 6'b101010, 1'b0);
    run_rotation_case("rot_ccw",   2'd2, '{8'd2, 8'd5, 8'd1, 8'd4, 8'd0, 8'd3}, 6'b101010, 1'b0);
`ifdef IMAGE_ROTATOR_ROT180_EN
    run_rotation_case("rot_180",   2'd3, '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}, 6'b100100, 1'b0);
`else
    run_rotation_case("mode3_fallback", 2'd3, '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5}, 6'b101010, 1'b1);
`endif
  endtask

  task automatic test_single_pixel();
    do_start(2'd0);
    send_pixel(8'hA5, 1'b1, 1'b1);
    capture();
    tests_run++; if (cap_n != 1)       begin tests_failed++; $display("[TB] FAIL px1_count got %0d want 1", cap_n); end
    tests_run++; if (cap_d[0] !== 8'hA5) begin tests_failed++; $display("[TB] FAIL px1_data got %h want a5", cap_d[0]); end
    tests_run++; if (cap_j[0] !== 1'b1)  begin tests_failed++; $display("[TB] FAIL px1_jump got %b want 1", cap_j[0]); end
    tests_run++; if (cap_e[0] !== 1'b1)  begin tests_failed++; $display("[TB] FAIL px1_eof got %b want 1", cap_e[0]); end
    tests_run++; if (err !== 1'b0)       begin tests_failed++; $display("[TB] FAIL px1_err got %b want 0", err); end
    tick();
  endtask

  task automatic test_row_mismatch();
    do_start(2'd0);
    send_pixel(8'd0, 1'b0, 1'b0);
    send_pixel(8'd1, 1'b0, 1'b0);
    send_pixel(8'd2, 1'b1, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_err_early got %b want 0", err); end
    send_pixel(8'd3, 1'b0, 1'b0);
    send_pixel(8'd4, 1'b1, 1'b1);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mismatch_err got %b want 1", err); end
    capture();
    tests_run++; if (cap_n != 6) begin tests_failed++; $display("[TB] FAIL mismatch_count got %0d want 6", cap_n); end
    tests_run++; if (cap_n < 1 || cap_n > 16 || cap_e[cap_n-1] !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL mismatch_eof no eof_out seen, count %0d", cap_n);
    end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mismatch_err_sticky got %b want 1", err); end
    tick();
  endtask

  task automatic test_reset_in_read();
    do_start(2'd0);
    send_frame_3x2();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("[TB] FAIL rst_read_busy got %b want 0", busy); end
    tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_read_valid got %b want 0", valid_out); end
    rst = 1'b0;
    tick();
    do_start(2'd1);
    send_frame_3x2();
    capture();
    tests_run++; if (cap_n != 6)        begin tests_failed++; $display("[TB] FAIL rst_fresh_count got %0d want 6", cap_n); end
    tests_run++; if (cap_d[0] !== 8'd3) begin tests_failed++; $display("[TB] FAIL rst_fresh_first got %0d want 3", cap_d[0]); end
    tests_run++; if (cap_d[5] !== 8'd2) begin tests_failed++; $display("[TB] FAIL rst_fresh_last got %0d want 2", cap_d[5]); end
    tests_run++; if (err !== 1'b0)      begin tests_failed++; $display("[TB] FAIL rst_fresh_err got %b want 0", err); end
    tick();
  endtask

  task automatic test_start_during_write();
    logic [PIX_W-1:0] exp_d [6];
    exp_d = '{8'd10, 8'd13, 8'd11, 8'd14, 8'd12, 8'd15};
    do_start(2'd0);
    send_pixel(8'd10, 1'b0, 1'b0);
    send_pixel(8'd11, 1'b0, 1'b0);
    send_pixel(8'd12, 1'b1, 1'b0);
    start_in = 1'b1;
    rot_mode = 2'd2;
    tick();
    start_in = 1'b0;
    send_pixel(8'd13, 1'b0, 1'b0);
    send_pixel(8'd14, 1'b0, 1'b0);
    send_pixel(8'd15, 1'b1, 1'b1);
    capture();
    tests_run++; if (cap_n != 6) begin tests_failed++; $display("[TB] FAIL restart_count got %0d want 6", cap_n); end
    for (int k = 0; k < 6 && k < cap_n; k++) begin
      tests_run++; if (cap_d[k] !== exp_d[k]) begin tests_failed++; $display("[TB] FAIL restart_data[%0d] got %0d want %0d", k, cap_d[k], exp_d[k]); end
    end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_err got %b want 0", err); end
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    start_in = 1'b0;
    rot_mode = 2'd0;
    valid_in = 1'b0;
    data_in  = '0;
    jump_in  = 1'b0;
    eof_in   = 1'b0;
    test_reset();
    test_modes();
    test_single_pixel();
    test_row_mismatch();
    test_reset_in_read();
    test_start_during_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
